div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 116 +++++++++++
 tb/tb_div.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Iterative RV32M divider: one restoring shift-subtract step per cycle,
// with sign fix-up, divide-by-zero and abort handling around the core loop.
module div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_start_i,
    input  logic [2:0]  div_op_i,
    input  logic [31:0] div_dividend_i,
    input  logic [31:0] div_divisor_i,
    input  logic [4:0]  div_rd_addr_i,
    input  logic        div_abort_i,
    output logic        div_busy_o,
    output logic        div_ready_o,
    output logic [31:0] div_result_o,
    output logic [4:0]  div_rd_addr_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_CALC, ST_END} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op;
    logic [31:0] dividend, divisor;
    logic [4:0]  rd_addr;
    logic [31:0] quo, rem, dvs;
    logic [4:0]  cnt;

    logic        is_signed, is_rem, div_zero, neg_q, neg_r, ge;
    logic [32:0] shifted, diff;
    logic [31:0] quo_fix, rem_fix, res_val;

    assign is_signed = op[2] & ~op[0];
    assign is_rem    = op[1];
    assign div_zero  = (divisor == 32'd0);
    assign neg_q     = is_signed & (dividend[31] ^ divisor[31]);
    assign neg_r     = is_signed & dividend[31];

    // quo doubles as the dividend shift register: its MSB feeds the remainder
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = ~diff[32];

    assign quo_fix = neg_q ? (~quo + 32'd1) : quo;
    assign rem_fix = neg_r ? (~rem + 32'd1) : rem;

    always_comb begin
        if (div_zero)
            res_val = is_rem ? dividend : 32'hFFFF_FFFF;
        else
            res_val = is_rem ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (div_start_i) state_nxt = ST_START;
            ST_START: begin
                if (div_abort_i)   state_nxt = ST_IDLE;
                else if (div_zero) state_nxt = ST_END;
                else               state_nxt = ST_CALC;
            end
            ST_CALC: begin
                if (div_abort_i)       state_nxt = ST_IDLE;
                else if (cnt == 5'd31) state_nxt = ST_END;
            end
            ST_END:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        div_busy_o    = (state == ST_START) || (state == ST_CALC);
        div_ready_o   = (state == ST_END);
        div_result_o  = div_ready_o ? res_val : 32'd0;
        div_rd_addr_o = div_ready_o ? rd_addr : 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= 3'd0;
            dividend <= 32'd0;
            divisor  <= 32'd0;
            rd_addr  <= 5'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            dvs      <= 32'd0;
            cnt      <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: if (div_start_i) begin
                    op       <= div_op_i;
                    dividend <= div_dividend_i;
                    divisor  <= div_divisor_i;
                    rd_addr  <= div_rd_addr_i;
                end
                ST_START: if (!div_zero) begin
                    quo <= (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
                    dvs <= (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;
                    rem <= 32'd0;
                    cnt <= 5'd0;
                end
                ST_CALC: begin
                    rem <= ge ? diff[31:0] : shifted[31:0];
                    quo <= {quo[30:0], ge};
                    cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Directed bench for the iterative divider: results, latency, busy window,
// divide-by-zero, overflow, abort, ignored restart and asynchronous reset.
module tb_div;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_start_i;
    logic [2:0]  div_op_i;
    logic [31:0] div_dividend_i;
    logic [31:0] div_divisor_i;
    logic [4:0]  div_rd_addr_i;
    logic        div_abort_i;
    logic        div_busy_o;
    logic        div_ready_o;
    logic [31:0] div_result_o;
    logic [4:0]  div_rd_addr_o;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    div dut (
        .clk(clk), .rst_n(rst_n),
        .div_start_i(div_start_i), .div_op_i(div_op_i),
        .div_dividend_i(div_dividend_i), .div_divisor_i(div_divisor_i),
        .div_rd_addr_i(div_rd_addr_i), .div_abort_i(div_abort_i),
        .div_busy_o(div_busy_o), .div_ready_o(div_ready_o),
        .div_result_o(div_result_o), .div_rd_addr_o(div_rd_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the falling edge of the START cycle (k=1).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        div_start_i = 1'b1; div_op_i = op; div_dividend_i = a;
        div_divisor_i = b; div_rd_addr_i = rd;
        @(negedge clk);
        div_start_i = 1'b0; div_dividend_i = 32'h5A5A_5A5A; div_divisor_i = 32'h0;
        div_rd_addr_i = 5'd31;
    endtask

    // Starting at cycle k0 (already at its falling edge), scan for ready.
    task automatic wait_ready(input int k0, output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = k0; k <= 40; k++) begin
            if (k > k0) @(negedge clk);
            if (div_ready_o) begin
                lat = k;
                break;
            end
            if (!div_busy_o) busy_ok = 1'b0;
        end
    endtask

    task automatic finish_op(input string tag, input int lat, input logic busy_ok,
                             input logic [31:0] exp_res, input logic [4:0] exp_rd, input int exp_lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_span"}, {31'd0, busy_ok}, 32'd1);
        if (lat != 0) begin
            chk({tag, "_res"}, div_result_o, exp_res);
            chk({tag, "_rd"}, {27'd0, div_rd_addr_o}, {27'd0, exp_rd});
            chk({tag, "_busy_end"}, {31'd0, div_busy_o}, 32'd0);
        end
        @(negedge clk);
        chk({tag, "_ready_drop"}, {31'd0, div_ready_o}, 32'd0);
        chk({tag, "_res_idle"}, div_result_o, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        logic busy_ok;
        issue(op, a, b, rd);
        wait_ready(1, lat, busy_ok);
        finish_op(tag, lat, busy_ok, exp_res, rd, exp_lat);
    endtask

    task automatic watch_no_ready(input string tag);
        logic seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_ready_o) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int lat;
        logic busy_ok;
        rst_n = 1'b0; div_start_i = 1'b0; div_op_i = 3'd0; div_dividend_i = 32'd0;
        div_divisor_i = 32'd0; div_rd_addr_i = 5'd0; div_abort_i = 1'b0;
        #12;
        chk("rst_busy", {31'd0, div_busy_o}, 32'd0);
        chk("rst_ready", {31'd0, div_ready_o}, 32'd0);
        chk("rst_res", div_result_o, 32'd0);
        chk("rst_rd", {27'd0, div_rd_addr_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("divu_100_7",  OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
        run_op("remu_100_7",  OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 34);
        run_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 34);
        run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 34);
        run_op("div_100_m7",  OP_DIV,  32'd100, 32'hFFFF_FFF9, 5'd9, 32'hFFFF_FFF2, 34);
        run_op("rem_100_m7",  OP_REM,  32'd100, 32'hFFFF_FFF9, 5'd10, 32'd2, 34);
        run_op("divu_max_1",  OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'hFFFF_FFFF, 34);
        run_op("div_by0",     OP_DIV,  32'h1234_5678, 32'd0, 5'd12, 32'hFFFF_FFFF, 2);
        run_op("remu_by0",    OP_REMU, 32'h1234_5678, 32'd0, 5'd13, 32'h1234_5678, 2);
        run_op("rem_m5_by0",  OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd14, 32'hFFFF_FFFB, 2);
        run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 34);
        run_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 34);

        // Abort mid-CALC: no result, then a fresh op completes normally.
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd1);
        for (int k = 2; k <= 10; k++) @(negedge clk);
        div_abort_i = 1'b1;
        @(negedge clk);
        div_abort_i = 1'b0;
        chk("abort_busy", {31'd0, div_busy_o}, 32'd0);
        watch_no_ready("abort_no_ready");
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd2, 32'd3, 34);

        // Abort together with start in IDLE: start wins.
        @(negedge clk);
        div_start_i = 1'b1; div_abort_i = 1'b1; div_op_i = OP_DIVU;
        div_dividend_i = 32'd9; div_divisor_i = 32'd3; div_rd_addr_i = 5'd3;
        @(negedge clk);
        div_start_i = 1'b0; div_abort_i = 1'b0;
        wait_ready(1, lat, busy_ok);
        finish_op("start_over_abort", lat, busy_ok, 32'd3, 5'd3, 34);

        // Abort in END must not swallow the ready pulse.
        issue(OP_DIV, 32'h1234_5678, 32'd0, 5'd4);
        @(negedge clk);
        div_abort_i = 1'b1;
        #1;
        chk("abort_end_ready", {31'd0, div_ready_o}, 32'd1);
        chk("abort_end_res", div_result_o, 32'hFFFF_FFFF);
        @(negedge clk);
        div_abort_i = 1'b0;
        chk("abort_end_drop", {31'd0, div_ready_o}, 32'd0);

        // Second start during CALC is ignored.
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
        for (int k = 2; k <= 5; k++) @(negedge clk);
        div_start_i = 1'b1; div_op_i = OP_REMU; div_dividend_i = 32'd50;
        div_divisor_i = 32'd5; div_rd_addr_i = 5'd9;
        @(negedge clk);
        div_start_i = 1'b0;
        wait_ready(6, lat, busy_ok);
        finish_op("restart_ignored", lat, busy_ok, 32'd14, 5'd5, 34);

        // Asynchronous reset mid-CALC.
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd1);
        for (int k = 2; k <= 20; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, div_busy_o}, 32'd0);
        chk("arst_ready", {31'd0, div_ready_o}, 32'd0);
        chk("arst_res", div_result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_ready("arst_no_ready");
        run_op("post_rst", OP_DIVU, 32'd9, 32'd3, 5'd2, 32'd3, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
